// File: rtl/encoder_pkg.sv
// Shared widths for the queued 8-to-3 encoder.
package encoder_pkg;

  localparam int unsigned N_LINES = 8;
  localparam int unsigned CODE_W  = 3;

endpackage : encoder_pkg

// File: rtl/prio_pick8.sv
// Combinational priority pick over an 8-bit vector: binary index, one-hot mask, any-set.
module prio_pick8
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N_LINES-1:0] vec,
  output logic [CODE_W-1:0]  sel_code,
  output logic [N_LINES-1:0] sel_mask,
  output logic               any
);

  // Scan so the last set bit visited is the winner: ascending for high-first, descending for low-first.
  always_comb begin
    sel_code = '0;
    any      = |vec;
    if (HIGH_FIRST) begin
      for (int i = 0; i < int'(N_LINES); i++) begin
        if (vec[i]) sel_code = CODE_W'(i);
      end
    end else begin
      for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
        if (vec[i]) sel_code = CODE_W'(i);
      end
    end
    sel_mask = any ? (N_LINES'(1) << sel_code) : '0;
  end

endmodule : prio_pick8

// File: rtl/encoder8_3_queued.sv
// Sticky pending register re-encoded into a priority-ordered index stream over valid/ready.
module encoder8_3_queued
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] req,
  output logic [CODE_W-1:0]  code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_LINES-1:0] pending,
  output logic               lost,
  output logic               idle
);

  logic [CODE_W-1:0]  sel_code;
  logic [N_LINES-1:0] sel_mask;
  logic               any;
  logic               slot_free;
  logic               load;
  logic [N_LINES-1:0] clr_mask;

  // Pick only from registered pending so a fresh req never races the output register.
  prio_pick8 #(
    .HIGH_FIRST (HIGH_FIRST)
  ) u_pick (
    .vec      (pending),
    .sel_code (sel_code),
    .sel_mask (sel_mask),
    .any      (any)
  );

  // Output slot can take a new index when empty or being consumed this edge.
  always_comb begin
    slot_free = !out_valid || out_ready;
    load      = slot_free && any;
    clr_mask  = load ? sel_mask : '0;
  end

  assign idle = (pending == '0) && !out_valid;

  // Pending accumulation, merge detection and output handshake register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      code      <= '0;
      out_valid <= 1'b0;
      lost      <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | req;
      lost    <= |(req & pending & ~clr_mask);
      if (slot_free) begin
        if (any) begin
          code      <= sel_code;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule : encoder8_3_queued

// File: tb/tb_encoder8_3_queued.sv
// Scoreboard bench: both priority orders driven by shared stimulus, checked against an event-level model.
module tb_encoder8_3_queued;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b1;

  logic [2:0] code_hi, code_lo;
  logic       valid_hi, valid_lo;
  logic [7:0] pend_hi, pend_lo;
  logic       lost_hi, lost_lo;
  logic       idle_hi, idle_lo;

  int checks = 0;
  int failures = 0;

  // Reference state per instance: index 0 = high-first, 1 = low-first.
  logic [7:0] m_pend[2] = '{8'h00, 8'h00};
  bit         m_valid[2] = '{1'b0, 1'b0};
  bit         m_lost[2] = '{1'b0, 1'b0};
  int         exp_hi[$];
  int         exp_lo[$];

  always #5 clk = ~clk;

  encoder8_3_queued #(.HIGH_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code_hi), .out_valid(valid_hi),
    .out_ready(out_ready), .pending(pend_hi), .lost(lost_hi), .idle(idle_hi)
  );

  encoder8_3_queued #(.HIGH_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code_lo), .out_valid(valid_lo),
    .out_ready(out_ready), .pending(pend_lo), .lost(lost_lo), .idle(idle_lo)
  );

  function automatic int pick(input logic [7:0] v, input bit hf);
    if (hf) begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut=%0d actual=%0h expected=%0h time=%0t", name, k, act, exp, $time);
    end
  endtask

  // Reference model: one step per edge from the behavioural rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k]  = 8'h00;
        m_valid[k] = 1'b0;
        m_lost[k]  = 1'b0;
      end
      exp_hi.delete();
      exp_lo.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] clr;
        int idx;
        clr = 8'h00;
        if (!m_valid[k] || out_ready) begin
          if (m_pend[k] != 8'h00) begin
            idx = pick(m_pend[k], k == 0);
            clr[idx] = 1'b1;
            if (k == 0) exp_hi.push_back(idx);
            else        exp_lo.push_back(idx);
            m_valid[k] = 1'b1;
          end else begin
            m_valid[k] = 1'b0;
          end
        end
        m_lost[k] = |(req & m_pend[k] & ~clr);
        m_pend[k] = (m_pend[k] & ~clr) | req;
      end
    end
  end

  task automatic check_dut(input int k, input logic [2:0] c, input logic v, input logic [7:0] p,
                           input logic l, input logic i);
    int front;
    chk("out_valid", k, int'(v), int'(m_valid[k]));
    chk("pending", k, int'(p), int'(m_pend[k]));
    chk("lost", k, int'(l), int'(m_lost[k]));
    chk("idle", k, int'(i), int'(m_pend[k] == 8'h00 && !m_valid[k]));
    if (v) begin
      if (k == 0) front = (exp_hi.size() > 0) ? exp_hi[0] : -1;
      else        front = (exp_lo.size() > 0) ? exp_lo[0] : -1;
      chk("code", k, int'(c), front);
      if (out_ready && rst_n) begin
        if (k == 0 && exp_hi.size() > 0) void'(exp_hi.pop_front());
        if (k == 1 && exp_lo.size() > 0) void'(exp_lo.pop_front());
      end
    end
  endtask

  // Monitor: compares on the falling edge, pops the scoreboard on each accepted index.
  always @(negedge clk) begin
    check_dut(0, code_hi, valid_hi, pend_hi, lost_hi, idle_hi);
    check_dut(1, code_lo, valid_lo, pend_lo, lost_lo, idle_lo);
  end

  task automatic cyc(input logic [7:0] r, input logic rdy);
    req = r;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_code"}, 0, int'(code_hi), 0);
    chk({name, "_code"}, 1, int'(code_lo), 0);
    chk({name, "_valid"}, 0, int'(valid_hi), 0);
    chk({name, "_valid"}, 1, int'(valid_lo), 0);
    chk({name, "_pend"}, 0, int'(pend_hi), 0);
    chk({name, "_pend"}, 1, int'(pend_lo), 0);
    chk({name, "_lost"}, 0, int'(lost_hi), 0);
    chk({name, "_lost"}, 1, int'(lost_lo), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Single request: pending after edge 1, code 5 after edge 2, drained after edge 3.
    cyc(8'h20, 1'b1);
    chk("single_pend", 0, int'(pend_hi), 8'h20);
    cyc(8'h00, 1'b1);
    chk("single_code", 0, int'(code_hi), 5);
    chk("single_valid", 0, int'(valid_hi), 1);
    cyc(8'h00, 1'b1);
    chk("single_drain", 0, int'(valid_hi), 0);
    chk("single_idle", 0, int'(idle_hi), 1);

    // Burst: high-first 7,4,1 and low-first 1,4,7 back to back.
    cyc(8'h92, 1'b1);
    cyc(8'h00, 1'b1);
    chk("burst_hi0", 0, int'(code_hi), 7);
    chk("burst_lo0", 1, int'(code_lo), 1);
    cyc(8'h00, 1'b1);
    chk("burst_hi1", 0, int'(code_hi), 4);
    chk("burst_lo1", 1, int'(code_lo), 4);
    cyc(8'h00, 1'b1);
    chk("burst_hi2", 0, int'(code_hi), 1);
    chk("burst_lo2", 1, int'(code_lo), 7);
    repeat (2) cyc(8'h00, 1'b1);

    // Back-pressure: code 3 holds while 0x40 accumulates, then 3 then 6.
    cyc(8'h08, 1'b0);
    cyc(8'h00, 1'b0);
    cyc(8'h40, 1'b0);
    repeat (3) cyc(8'h00, 1'b0);
    chk("bp_hold_code", 0, int'(code_hi), 3);
    chk("bp_pend", 0, int'(pend_hi), 8'h40);
    repeat (4) cyc(8'h00, 1'b1);

    // Lost: second 0x04 merges into a stalled pending bit.
    cyc(8'h10, 1'b0);
    cyc(8'h00, 1'b0);
    cyc(8'h04, 1'b0);
    repeat (2) cyc(8'h00, 1'b0);
    cyc(8'h04, 1'b0);
    chk("lost_pulse", 0, int'(lost_hi), 1);
    cyc(8'h00, 1'b0);
    chk("lost_clear", 0, int'(lost_hi), 0);
    repeat (5) cyc(8'h00, 1'b1);

    // Re-request on the clear edge: code 0 twice, no lost.
    cyc(8'h01, 1'b1);
    cyc(8'h01, 1'b1);
    chk("rereq_lost", 0, int'(lost_hi), 0);
    chk("rereq_pend", 0, int'(pend_hi), 8'h01);
    repeat (4) cyc(8'h00, 1'b1);

    // Randomised traffic with random back-pressure.
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cyc(r, $urandom_range(0, 3) != 0);
    end
    repeat (20) cyc(8'h00, 1'b1);
    chk("drain_q", 0, exp_hi.size(), 0);
    chk("drain_q", 1, exp_lo.size(), 0);

    // Mid-operation async reset between edges drops everything.
    repeat (3) cyc(8'hFF, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    rst_n = 1'b1;
    repeat (5) cyc(8'h00, 1'b1);
    chk("post_reset_valid", 0, int'(valid_hi), 0);
    chk("post_reset_idle", 1, int'(idle_lo), 1);
    cyc(8'h24, 1'b1);
    repeat (5) cyc(8'h00, 1'b1);
    chk("final_q", 0, exp_hi.size(), 0);
    chk("final_q", 1, exp_lo.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_encoder8_3_queued
